block_shifter_arbiter: RTL

Shares one two-lane block shifter among NUM_REQ variable-length block producers. Each cycle it grants up to two requesters in round-robin order and registers their payloads onto shifter lanes 0 and 1, so the shifter concatenates them into one packed output word. It tracks per-requester end-of-stream, drives the shifter's `in_last` so that the merged stream ends exactly once, then pulses `done` and re-arms for the next batch.

---
 rtl/block_shifter_pkg.sv | 26 ++
 rtl/block_shifter_arbiter_rr_pick2.sv | 41 ++++
 rtl/block_shifter_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/block_shifter_pkg.sv
// Shared types and constants for the two-lane block shifter arbiter.
package block_shifter_pkg;

  localparam int unsigned BLOCK_SIZE     = 64;
  localparam int unsigned MAX_NUM_BLOCKS = 1;
  localparam int unsigned LANE_W         = BLOCK_SIZE * MAX_NUM_BLOCKS;
  localparam int unsigned NUM_W          = 32;

  typedef struct packed {
    logic [LANE_W-1:0] data;
    logic [NUM_W-1:0]  num;
    logic              last;
  } lane_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  // Oversized block counts are limited to what one lane can carry.
  function automatic logic [NUM_W-1:0] clamp_num(input logic [NUM_W-1:0] n);
    return (n > NUM_W'(MAX_NUM_BLOCKS)) ? NUM_W'(MAX_NUM_BLOCKS) : n;
  endfunction

endpackage

// File: rtl/block_shifter_arbiter_rr_pick2.sv
// Round-robin picker: first two set bits of i_req at or after i_ptr, plus the
// pointer that follows the last grant in round-robin order.
module block_shifter_arbiter_rr_pick2 #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_gnt0,
  output logic [NUM_REQ-1:0]         o_gnt1,
  output logic                       o_vld0,
  output logic                       o_vld1,
  output logic [$clog2(NUM_REQ)-1:0] o_next_ptr
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  always_comb begin
    int unsigned idx;
    o_gnt0     = '0;
    o_gnt1     = '0;
    o_vld0     = 1'b0;
    o_vld1     = 1'b0;
    o_next_ptr = i_ptr;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(i_ptr) + k) % NUM_REQ;
      if (i_req[PW'(idx)]) begin
        if (!o_vld0) begin
          o_gnt0[PW'(idx)] = 1'b1;
          o_vld0           = 1'b1;
          o_next_ptr       = (idx + 1 == NUM_REQ) ? '0 : PW'(idx + 1);
        end else if (!o_vld1) begin
          o_gnt1[PW'(idx)] = 1'b1;
          o_vld1           = 1'b1;
          o_next_ptr       = (idx + 1 == NUM_REQ) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

endmodule

// File: rtl/block_shifter_arbiter.sv
// Grants up to two block producers per cycle onto the shifter's two lanes and
// merges their end-of-stream flags so the shifter sees exactly one final beat.
module block_shifter_arbiter
  import block_shifter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][LANE_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0][NUM_W-1:0]    req_num,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [1:0]                       sh_in_ready,
  output logic [1:0]                       sh_in_valid,
  output logic [1:0][LANE_W-1:0]           sh_in_data,
  output logic [1:0][NUM_W-1:0]            sh_in_num,
  output logic [1:0]                       sh_in_last,
  output logic                             done,
  output logic                             num_err
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [NUM_REQ-1:0]  r_done_mask;
  logic [PW-1:0]       r_rr_ptr;
  lane_t [1:0]         r_lane;
  logic [1:0]          r_valid;
  logic                r_done;
  logic                r_num_err;

  logic [NUM_REQ-1:0]  w_cand;
  logic [NUM_REQ-1:0]  w_gnt0;
  logic [NUM_REQ-1:0]  w_gnt1;
  logic                w_vld0;
  logic                w_vld1;
  logic [PW-1:0]       w_next_ptr;
  logic [NUM_REQ-1:0]  w_granted;
  logic [NUM_REQ-1:0]  w_granted_last;
  logic                w_load;
  logic                w_final;
  logic                w_xfer;
  logic                w_done_nxt;
  logic                w_over;
  lane_t [1:0]         w_sel;

  assign w_cand = req_valid & ~r_done_mask;

  block_shifter_arbiter_rr_pick2 #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req      (w_cand),
    .i_ptr      (r_rr_ptr),
    .o_gnt0     (w_gnt0),
    .o_gnt1     (w_gnt1),
    .o_vld0     (w_vld0),
    .o_vld1     (w_vld1),
    .o_next_ptr (w_next_ptr)
  );

  assign w_load         = (r_state == RUN) && (!(|r_valid) || (&sh_in_ready));
  assign w_xfer         = &sh_in_ready;
  assign w_granted      = w_gnt0 | w_gnt1;
  assign w_granted_last = w_granted & req_last;
  assign w_final        = w_load && (&(r_done_mask | w_granted_last));
  // Combinational handshake back to the producers.
  assign req_ready      = w_load ? w_granted : '0;

  // Lane payload mux; last is broadcast to both lanes on the final load only.
  always_comb begin
    w_sel  = '0;
    w_over = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt0[i]) begin
        w_sel[0].data = req_data[i];
        w_sel[0].num  = clamp_num(req_num[i]);
        if (req_num[i] > NUM_W'(MAX_NUM_BLOCKS)) w_over = 1'b1;
      end
      if (w_gnt1[i]) begin
        w_sel[1].data = req_data[i];
        w_sel[1].num  = clamp_num(req_num[i]);
        if (req_num[i] > NUM_W'(MAX_NUM_BLOCKS)) w_over = 1'b1;
      end
    end
    w_sel[0].last = w_final;
    w_sel[1].last = w_final;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      RUN:     if (w_final) w_state_nxt = FLUSH;
      FLUSH:   if (w_xfer)  w_state_nxt = DONE;
      DONE:    w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
    w_done_nxt = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lane      <= '0;
      r_valid     <= '0;
      r_done_mask <= '0;
      r_rr_ptr    <= '0;
      r_done      <= 1'b0;
      r_num_err   <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_load) begin
        r_lane      <= w_sel;
        r_valid     <= {w_vld1, w_vld0};
        r_done_mask <= r_done_mask | w_granted_last;
        if (w_vld0) r_rr_ptr <= w_next_ptr;
        if (w_over) r_num_err <= 1'b1;
      end else if ((r_state == FLUSH) && w_xfer) begin
        r_lane  <= '0;
        r_valid <= '0;
      end else if (r_state == DONE) begin
        r_done_mask <= '0;
        r_rr_ptr    <= '0;
      end
    end
  end

  assign sh_in_valid   = r_valid;
  assign sh_in_data[0] = r_lane[0].data;
  assign sh_in_data[1] = r_lane[1].data;
  assign sh_in_num[0]  = r_lane[0].num;
  assign sh_in_num[1]  = r_lane[1].num;
  assign sh_in_last    = {r_lane[1].last, r_lane[0].last};
  assign done          = r_done;
  assign num_err       = r_num_err;

endmodule
